// File: rtl/trap_controller_if.sv
// CSR write port and pipeline redirect bundle driven by the trap sequencer.
interface trap_controller_if #(
  parameter int XLEN = 32
);
  logic            csr_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            busy_o;
  logic            redirect_valid_o;
  logic [XLEN-1:0] redirect_pc_o;

  modport master (
    output csr_we_o, csr_addr_o, csr_wdata_o, busy_o, redirect_valid_o, redirect_pc_o
  );
  modport slave (
    input  csr_we_o, csr_addr_o, csr_wdata_o, busy_o, redirect_valid_o, redirect_pc_o
  );
endinterface

// File: rtl/trap_controller.sv
// M-mode trap sequencer: fixed-priority exception capture, mepc/mcause/mtval writeback, redirect, mret.
// Define TRAP_IRQ_EN to add irq_i/mie_i and take external interrupts.
//
// state   | meaning
// IDLE    | waiting for exception, interrupt or mret
// W_EPC   | writing mepc
// W_CAUSE | writing mcause
// W_TVAL  | writing mtval
// REDIR   | redirect to trap vector
// MRET_R  | redirect to latched mepc
module trap_controller #(
  parameter int              NUM_SRC  = 4,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_SRC-1:0]      exc_req_i,
  input  logic [NUM_SRC*4-1:0]    exc_cause_i,
  input  logic [NUM_SRC*XLEN-1:0] exc_tval_i,
  input  logic [XLEN-1:0]         exc_pc_i,
  input  logic                    mret_i,
  input  logic [XLEN-1:0]         mepc_i,
`ifdef TRAP_IRQ_EN
  input  logic                    irq_i,
  input  logic                    mie_i,
`endif
  trap_controller_if.master       bus
);

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-5){1'b0}}, 4'd11};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_TVAL  = 3'd3,
    REDIR   = 3'd4,
    MRET_R  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            int_q, int_d;

  logic            take_irq;
  logic [3:0]      cause_sel;
  logic [XLEN-1:0] tval_sel;

`ifdef TRAP_IRQ_EN
  assign take_irq = irq_i & mie_i;
`else
  assign take_irq = 1'b0;
`endif

  // Walk from the top down so the lowest set index is the one that sticks.
  always_comb begin
    cause_sel = '0;
    tval_sel  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_req_i[i]) begin
        cause_sel = exc_cause_i[4*i +: 4];
        tval_sel  = exc_tval_i[XLEN*i +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
      int_q   <= int_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    tval_d  = tval_q;
    int_d   = int_q;
    case (state_q)
      IDLE: begin
        if (|exc_req_i) begin
          pc_d    = exc_pc_i;
          cause_d = cause_sel;
          tval_d  = tval_sel;
          int_d   = 1'b0;
          state_d = W_EPC;
        end else if (take_irq) begin
          pc_d    = exc_pc_i;
          cause_d = '0;
          tval_d  = '0;
          int_d   = 1'b1;
          state_d = W_EPC;
        end else if (mret_i) begin
          // pc_q doubles as the mret return target
          pc_d    = mepc_i;
          state_d = MRET_R;
        end
      end
      W_EPC:   state_d = W_CAUSE;
      W_CAUSE: state_d = W_TVAL;
      W_TVAL:  state_d = REDIR;
      REDIR:   state_d = IDLE;
      MRET_R:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.csr_we_o         = 1'b0;
    bus.csr_addr_o       = '0;
    bus.csr_wdata_o      = '0;
    bus.busy_o           = (state_q != IDLE);
    bus.redirect_valid_o = 1'b0;
    bus.redirect_pc_o    = '0;
    case (state_q)
      W_EPC: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MEPC;
        bus.csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
      end
      W_CAUSE: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MCAUSE;
        bus.csr_wdata_o = int_q ? IRQ_CAUSE : {{(XLEN-4){1'b0}}, cause_q};
      end
      W_TVAL: begin
        bus.csr_we_o    = 1'b1;
        bus.csr_addr_o  = CSR_MTVAL;
        bus.csr_wdata_o = tval_q;
      end
      REDIR: begin
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = TRAP_VEC;
      end
      MRET_R: begin
        bus.redirect_valid_o = 1'b1;
        bus.redirect_pc_o    = pc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exception priority, CSR write sequence, mret, reset abort, optional IRQ.
module tb_trap_controller;
  localparam int NUM_SRC = 4;
  localparam int XLEN    = 32;
  localparam logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic [NUM_SRC-1:0]      exc_req_i;
  logic [NUM_SRC*4-1:0]    exc_cause_i;
  logic [NUM_SRC*XLEN-1:0] exc_tval_i;
  logic [XLEN-1:0]         exc_pc_i;
  logic                    mret_i;
  logic [XLEN-1:0]         mepc_i;
`ifdef TRAP_IRQ_EN
  logic                    irq_i;
  logic                    mie_i;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  trap_controller_if #(.XLEN(XLEN)) bus ();

  trap_controller #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .TRAP_VEC(TRAP_VEC)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .exc_req_i   (exc_req_i),
    .exc_cause_i (exc_cause_i),
    .exc_tval_i  (exc_tval_i),
    .exc_pc_i    (exc_pc_i),
    .mret_i      (mret_i),
    .mepc_i      (mepc_i),
`ifdef TRAP_IRQ_EN
    .irq_i       (irq_i),
    .mie_i       (mie_i),
`endif
    .bus         (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_req();
    exc_req_i = '0;
    mret_i    = 1'b0;
`ifdef TRAP_IRQ_EN
    irq_i     = 1'b0;
`endif
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, ".we"},   bus.csr_we_o, 1'b0);
    chk({tag, ".addr"}, bus.csr_addr_o, 12'h000);
    chk({tag, ".wd"},   bus.csr_wdata_o, 32'h0);
    chk({tag, ".busy"}, bus.busy_o, 1'b0);
    chk({tag, ".rv"},   bus.redirect_valid_o, 1'b0);
    chk({tag, ".rpc"},  bus.redirect_pc_o, 32'h0);
  endtask

  // Inputs already applied; runs the full 4-cycle trap sequence and returns to IDLE.
  task automatic run_seq(input string tag, input logic [31:0] epc,
                         input logic [31:0] cause, input logic [31:0] tval);
    tick();
    clear_req();
    chk({tag, ".epc_we"},   bus.csr_we_o, 1'b1);
    chk({tag, ".epc_addr"}, bus.csr_addr_o, 12'h341);
    chk({tag, ".epc_wd"},   bus.csr_wdata_o, epc);
    chk({tag, ".epc_busy"}, bus.busy_o, 1'b1);
    chk({tag, ".epc_rv"},   bus.redirect_valid_o, 1'b0);
    tick();
    chk({tag, ".cause_addr"}, bus.csr_addr_o, 12'h342);
    chk({tag, ".cause_wd"},   bus.csr_wdata_o, cause);
    tick();
    chk({tag, ".tval_addr"}, bus.csr_addr_o, 12'h343);
    chk({tag, ".tval_wd"},   bus.csr_wdata_o, tval);
    chk({tag, ".tval_we"},   bus.csr_we_o, 1'b1);
    tick();
    chk({tag, ".redir_we"},   bus.csr_we_o, 1'b0);
    chk({tag, ".redir_wd"},   bus.csr_wdata_o, 32'h0);
    chk({tag, ".redir_rv"},   bus.redirect_valid_o, 1'b1);
    chk({tag, ".redir_pc"},   bus.redirect_pc_o, 32'h0000_0100);
    chk({tag, ".redir_busy"}, bus.busy_o, 1'b1);
    tick();
    idle_outputs({tag, ".end"});
  endtask

  initial begin
    rst_i       = 1'b1;
    exc_cause_i = '0;
    exc_tval_i  = '0;
    exc_pc_i    = '0;
    mepc_i      = '0;
`ifdef TRAP_IRQ_EN
    mie_i       = 1'b0;
`endif
    clear_req();
    tick();
    tick();
    idle_outputs("reset");
    rst_i = 1'b0;
    tick();
    idle_outputs("post_reset");

    exc_cause_i = {4'hB, 4'h2, 4'h5, 4'h7};
    exc_tval_i  = {32'h3333_4444, 32'hDEAD_BEEF, 32'h1111_2222, 32'hAAAA_5555};

    // single source 2
    exc_req_i = 4'b0100;
    exc_pc_i  = 32'h0000_1004;
    run_seq("src2", 32'h0000_1004, 32'h2, 32'hDEAD_BEEF);

    // sources 1 and 3: source 1 wins; PC low bits masked
    exc_req_i = 4'b1010;
    exc_pc_i  = 32'h0000_2003;
    run_seq("src1of3", 32'h0000_2000, 32'h5, 32'h1111_2222);

    // lowest priority source alone
    exc_req_i = 4'b1000;
    exc_pc_i  = 32'h0000_4008;
    run_seq("src3", 32'h0000_4008, 32'hB, 32'h3333_4444);

    // mret
    mret_i = 1'b1;
    mepc_i = 32'h0000_2000;
    tick();
    clear_req();
    chk("mret.rv",   bus.redirect_valid_o, 1'b1);
    chk("mret.pc",   bus.redirect_pc_o, 32'h0000_2000);
    chk("mret.we",   bus.csr_we_o, 1'b0);
    chk("mret.busy", bus.busy_o, 1'b1);
    tick();
    idle_outputs("mret.end");

    // exception beats mret
    exc_req_i = 4'b0001;
    mret_i    = 1'b1;
    mepc_i    = 32'h0000_5000;
    exc_pc_i  = 32'h0000_600C;
    run_seq("exc_vs_mret", 32'h0000_600C, 32'h7, 32'hAAAA_5555);

    // requests raised while busy are ignored
    exc_req_i = 4'b0010;
    exc_pc_i  = 32'h0000_7000;
    tick();
    clear_req();
    mret_i    = 1'b1;
    mepc_i    = 32'h0000_9000;
    exc_req_i = 4'b0001;
    tick();
    tick();
    clear_req();
    tick();
    chk("busy_ign.rpc", bus.redirect_pc_o, 32'h0000_0100);
    tick();
    idle_outputs("busy_ign.end");

    // reset during W_CAUSE aborts the sequence
    exc_req_i = 4'b0100;
    exc_pc_i  = 32'h0000_1004;
    tick();
    clear_req();
    tick();
    chk("rst.in_cause", bus.csr_addr_o, 12'h342);
    rst_i = 1'b1;
    tick();
    idle_outputs("rst.abort");
    rst_i = 1'b0;
    tick();
    idle_outputs("rst.after");

`ifdef TRAP_IRQ_EN
    irq_i    = 1'b1;
    mie_i    = 1'b1;
    exc_pc_i = 32'h0000_3000;
    run_seq("irq", 32'h0000_3000, 32'h8000_000B, 32'h0);
    irq_i = 1'b1;
    mie_i = 1'b0;
    tick();
    idle_outputs("irq_masked");
    tick();
    idle_outputs("irq_masked2");
    irq_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
